prop_sequencer: RTL and testbench

Sequences forward and backward propagation across a stack of perceptron-unit layers. It issues one-cycle per-layer `fd_prop` strobes in layer order, then (training only) `bk_prop` strobes in reverse order. It drives the shared `oscillator` line and counts completed samples. It sits between the sample loader and the layer array; every unit in layer k takes its `fd_prop`/`bk_prop` from bit k of this block's outputs.

---
 rtl/prop_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_prop_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prop_sequencer.sv
// prop_sequencer
//   Sequences forward strobes over a stack of layers, optionally followed by
//   backward strobes in reverse order. It drives the shared oscillator line
//   and counts completed passes.
//
// Ports
//   clk_in, rst_in      : rising-edge clock, synchronous active-high reset
//   start_in, train_in  : request a pass; train_in=1 adds the backward sweep
//   abort_in            : drop the current pass and return to idle
//   ready_out/busy_out  : idle / not idle
//   fd_prop_out         : one-hot forward strobe per layer (or zero)
//   bk_prop_out         : one-hot backward strobe per layer (or zero)
//   oscillator_out      : toggles once per completed pass
//   phase_out           : 0 idle, 1 forward, 2 backward, 3 done
//   done_out            : one-cycle pulse when a pass completes
//   sample_count_out    : completed-pass counter (wraps)
module prop_sequencer #(
    parameter int NUM_LAYERS    = 4,
    parameter int SETTLE_CYCLES = 0,
    parameter int COUNT_W       = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  train_in,
    input  logic                  abort_in,
    output logic                  ready_out,
    output logic                  busy_out,
    output logic [NUM_LAYERS-1:0] fd_prop_out,
    output logic [NUM_LAYERS-1:0] bk_prop_out,
    output logic                  oscillator_out,
    output logic [1:0]            phase_out,
    output logic                  done_out,
    output logic [COUNT_W-1:0]    sample_count_out
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [LW-1:0] LAST_LAYER  = LW'(NUM_LAYERS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_FWD_WAIT,
        S_BWD,
        S_BWD_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic   [LW-1:0]     r_layer;
    logic   [SW-1:0]     r_settle;
    logic                r_train;
    logic                r_osc;
    logic   [COUNT_W-1:0] r_count;

    state_t              w_state_nxt;
    logic   [LW-1:0]     w_layer_nxt;
    logic   [SW-1:0]     w_settle_nxt;
    logic                w_train_nxt;
    logic                w_fwd_adv;
    logic                w_bwd_adv;
    logic [NUM_LAYERS-1:0] w_onehot;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state  <= S_IDLE;
            r_layer  <= '0;
            r_settle <= '0;
            r_train  <= 1'b0;
            r_osc    <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_layer  <= w_layer_nxt;
            r_settle <= w_settle_nxt;
            r_train  <= w_train_nxt;
            // The DONE cycle has already been presented, so it is counted
            // even if abort arrives in that same cycle.
            if (r_state == S_DONE) begin
                r_count <= r_count + COUNT_W'(1);
                r_osc   <= ~r_osc;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_layer_nxt  = r_layer;
        w_settle_nxt = r_settle;
        w_train_nxt  = r_train;
        w_fwd_adv    = 1'b0;
        w_bwd_adv    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_in && !abort_in) begin
                    w_train_nxt  = train_in;
                    w_layer_nxt  = '0;
                    w_settle_nxt = '0;
                    w_state_nxt  = S_FWD;
                end
            end
            S_FWD: begin
                if (SETTLE_CYCLES > 0) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = S_FWD_WAIT;
                end else begin
                    w_fwd_adv = 1'b1;
                end
            end
            S_FWD_WAIT: begin
                if (r_settle == SETTLE_LAST) w_fwd_adv = 1'b1;
                else w_settle_nxt = r_settle + SW'(1);
            end
            S_BWD: begin
                if (SETTLE_CYCLES > 0) begin
                    w_settle_nxt = '0;
                    w_state_nxt  = S_BWD_WAIT;
                end else begin
                    w_bwd_adv = 1'b1;
                end
            end
            S_BWD_WAIT: begin
                if (r_settle == SETTLE_LAST) w_bwd_adv = 1'b1;
                else w_settle_nxt = r_settle + SW'(1);
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Layer stepping is shared by the strobe state (no settle) and the
        // last settle cycle, so it is resolved once here.
        if (w_fwd_adv) begin
            if (r_layer != LAST_LAYER) begin
                w_layer_nxt = r_layer + LW'(1);
                w_state_nxt = S_FWD;
            end else if (r_train) begin
                w_layer_nxt = LAST_LAYER;
                w_state_nxt = S_BWD;
            end else begin
                w_state_nxt = S_DONE;
            end
        end

        if (w_bwd_adv) begin
            if (r_layer != '0) begin
                w_layer_nxt = r_layer - LW'(1);
                w_state_nxt = S_BWD;
            end else begin
                w_state_nxt = S_DONE;
            end
        end

        if (abort_in && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_layer_nxt = '0;
        end
    end

    always_comb begin
        w_onehot         = NUM_LAYERS'(1) << r_layer;
        ready_out        = (r_state == S_IDLE);
        busy_out         = (r_state != S_IDLE);
        done_out         = (r_state == S_DONE);
        fd_prop_out      = (r_state == S_FWD) ? w_onehot : '0;
        bk_prop_out      = (r_state == S_BWD) ? w_onehot : '0;
        oscillator_out   = r_osc;
        sample_count_out = r_count;
        case (r_state)
            S_FWD, S_FWD_WAIT: phase_out = 2'd1;
            S_BWD, S_BWD_WAIT: phase_out = 2'd2;
            S_DONE:            phase_out = 2'd3;
            default:           phase_out = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_prop_sequencer.sv
module tb_prop_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // dut0: N=4, S=0, 2-bit counter
    logic       a_rst, a_start, a_train, a_abort;
    logic       a_ready, a_busy, a_osc, a_done;
    logic [3:0] a_fd, a_bk;
    logic [1:0] a_phase;
    logic [1:0] a_count;

    // dut1: N=4, S=2
    logic       b_rst, b_start, b_train, b_abort;
    logic       b_ready, b_busy, b_osc, b_done;
    logic [3:0] b_fd, b_bk;
    logic [1:0] b_phase;
    logic [15:0] b_count;

    // dut2: N=1, S=0
    logic       c_rst, c_start, c_train, c_abort;
    logic       c_ready, c_busy, c_osc, c_done;
    logic [0:0] c_fd, c_bk;
    logic [1:0] c_phase;
    logic [15:0] c_count;

    prop_sequencer #(.NUM_LAYERS(4), .SETTLE_CYCLES(0), .COUNT_W(2)) dut0 (
        .clk_in(clk), .rst_in(a_rst), .start_in(a_start), .train_in(a_train),
        .abort_in(a_abort), .ready_out(a_ready), .busy_out(a_busy),
        .fd_prop_out(a_fd), .bk_prop_out(a_bk), .oscillator_out(a_osc),
        .phase_out(a_phase), .done_out(a_done), .sample_count_out(a_count)
    );

    prop_sequencer #(.NUM_LAYERS(4), .SETTLE_CYCLES(2), .COUNT_W(16)) dut1 (
        .clk_in(clk), .rst_in(b_rst), .start_in(b_start), .train_in(b_train),
        .abort_in(b_abort), .ready_out(b_ready), .busy_out(b_busy),
        .fd_prop_out(b_fd), .bk_prop_out(b_bk), .oscillator_out(b_osc),
        .phase_out(b_phase), .done_out(b_done), .sample_count_out(b_count)
    );

    prop_sequencer #(.NUM_LAYERS(1), .SETTLE_CYCLES(0), .COUNT_W(16)) dut2 (
        .clk_in(clk), .rst_in(c_rst), .start_in(c_start), .train_in(c_train),
        .abort_in(c_abort), .ready_out(c_ready), .busy_out(c_busy),
        .fd_prop_out(c_fd), .bk_prop_out(c_bk), .oscillator_out(c_osc),
        .phase_out(c_phase), .done_out(c_done), .sample_count_out(c_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; c_rst = 1;
        step();
        step();
        a_rst = 0; b_rst = 0; c_rst = 0;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
        checks++; if (a_fd !== 4'b0 || a_bk !== 4'b0) begin errors++; $display("FAIL reset_strobes fd=%b bk=%b exp=0", a_fd, a_bk); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
        checks++; if (a_osc !== 1'b0) begin errors++; $display("FAIL reset_osc got=%b exp=0", a_osc); end
        checks++; if (a_phase !== 2'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", a_phase); end
        checks++; if (a_count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        checks++; if (b_ready !== 1'b1 || c_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_others b=%b c=%b exp=1", b_ready, c_ready); end
    endtask

    task automatic test_inference();
        logic [3:0] exp_fd;
        a_train = 0; a_start = 1;
        step();
        a_start = 0;
        checks++; if (a_busy !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL inf_busy busy=%b ready=%b exp=1/0", a_busy, a_ready); end
        for (int k = 0; k < 4; k++) begin
            exp_fd = 4'(1 << k);
            checks++; if (a_fd !== exp_fd) begin errors++; $display("FAIL inf_fd k=%0d got=%b exp=%b", k, a_fd, exp_fd); end
            checks++; if (a_bk !== 4'b0) begin errors++; $display("FAIL inf_bk k=%0d got=%b exp=0000", k, a_bk); end
            checks++; if (a_phase !== 2'd1) begin errors++; $display("FAIL inf_phase k=%0d got=%0d exp=1", k, a_phase); end
            step();
        end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL inf_done got=%b exp=1", a_done); end
        checks++; if (a_phase !== 2'd3) begin errors++; $display("FAIL inf_done_phase got=%0d exp=3", a_phase); end
        checks++; if (a_fd !== 4'b0 || a_bk !== 4'b0) begin errors++; $display("FAIL inf_done_strobes fd=%b bk=%b exp=0", a_fd, a_bk); end
        step();
        checks++; if (a_ready !== 1'b1 || a_done !== 1'b0) begin errors++; $display("FAIL inf_idle ready=%b done=%b exp=1/0", a_ready, a_done); end
        checks++; if (a_count !== 2'd1) begin errors++; $display("FAIL inf_count got=%0d exp=1", a_count); end
        checks++; if (a_osc !== 1'b1) begin errors++; $display("FAIL inf_osc got=%b exp=1", a_osc); end
    endtask

    task automatic test_abort_in_idle();
        a_start = 1; a_abort = 1;
        step();
        a_start = 0; a_abort = 0;
        checks++; if (a_ready !== 1'b1 || a_fd !== 4'b0) begin errors++; $display("FAIL idle_abort_blocks_start ready=%b fd=%b exp=1/0000", a_ready, a_fd); end
    endtask

    task automatic test_abort();
        logic [1:0] saved_count;
        logic       saved_osc;
        int         n_done;
        saved_count = a_count;
        saved_osc   = a_osc;
        a_train = 1; a_start = 1;
        step();
        a_start = 0;
        for (int i = 0; i < 5; i++) step();
        checks++; if (a_bk !== 4'b0100 || a_fd !== 4'b0) begin errors++; $display("FAIL abort_setup bk=%b fd=%b exp=0100/0000", a_bk, a_fd); end
        a_abort = 1;
        step();
        a_abort = 0;
        checks++; if (a_ready !== 1'b1 || a_phase !== 2'd0) begin errors++; $display("FAIL abort_idle ready=%b phase=%0d exp=1/0", a_ready, a_phase); end
        checks++; if (a_fd !== 4'b0 || a_bk !== 4'b0) begin errors++; $display("FAIL abort_strobes fd=%b bk=%b exp=0", a_fd, a_bk); end
        n_done = (a_done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (a_done === 1'b1) n_done++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
        checks++; if (a_count !== saved_count) begin errors++; $display("FAIL abort_count got=%0d exp=%0d", a_count, saved_count); end
        checks++; if (a_osc !== saved_osc) begin errors++; $display("FAIL abort_osc got=%b exp=%b", a_osc, saved_osc); end
    endtask

    task automatic test_reset_mid();
        a_train = 0; a_start = 1;
        step();
        a_start = 0;
        step();
        checks++; if (a_fd !== 4'b0010) begin errors++; $display("FAIL rstmid_setup fd=%b exp=0010", a_fd); end
        a_rst = 1;
        step();
        a_rst = 0;
        checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_ready ready=%b busy=%b exp=1/0", a_ready, a_busy); end
        checks++; if (a_fd !== 4'b0 || a_bk !== 4'b0 || a_done !== 1'b0) begin errors++; $display("FAIL rstmid_strobes fd=%b bk=%b done=%b exp=0", a_fd, a_bk, a_done); end
        checks++; if (a_count !== 2'd0 || a_osc !== 1'b0 || a_phase !== 2'd0) begin errors++; $display("FAIL rstmid_state count=%0d osc=%b phase=%0d exp=0/0/0", a_count, a_osc, a_phase); end
        a_start = 1;
        step();
        a_start = 0;
        checks++; if (a_fd !== 4'b0001) begin errors++; $display("FAIL rstmid_restart fd=%b exp=0001", a_fd); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (a_fd !== 4'b1000) begin errors++; $display("FAIL rstmid_last fd=%b exp=1000", a_fd); end
        step();
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rstmid_done got=%b exp=1", a_done); end
        step();
        checks++; if (a_count !== 2'd1 || a_ready !== 1'b1) begin errors++; $display("FAIL rstmid_count count=%0d ready=%b exp=1/1", a_count, a_ready); end
    endtask

    task automatic test_busy_wrap();
        int n_done;
        a_rst = 1;
        step();
        a_rst = 0;
        a_train = 0; a_start = 1;
        step();
        a_start = 0;
        step();
        a_start = 1;
        step();
        a_start = 0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (a_done === 1'b1) n_done++;
        end
        checks++; if (n_done != 1) begin errors++; $display("FAIL busy_start_ignored done_pulses=%0d exp=1", n_done); end
        checks++; if (a_count !== 2'd1 || a_osc !== 1'b1) begin errors++; $display("FAIL wrap_pass1 count=%0d osc=%b exp=1/1", a_count, a_osc); end
        for (int p = 2; p <= 5; p++) begin
            a_start = 1;
            step();
            a_start = 0;
            for (int i = 0; i < 4; i++) step();
            checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL wrap_done pass=%0d got=%b exp=1", p, a_done); end
            step();
            checks++; if (a_count !== 2'(p)) begin errors++; $display("FAIL wrap_count pass=%0d got=%0d exp=%0d", p, a_count, 2'(p)); end
            checks++; if (a_osc !== 1'(p % 2)) begin errors++; $display("FAIL wrap_osc pass=%0d got=%b exp=%0d", p, a_osc, p % 2); end
        end
    endtask

    task automatic test_training();
        logic [3:0] exp_fd, exp_bk;
        logic       exp_done;
        b_train = 1; b_start = 1;
        step();
        b_start = 0;
        for (int c = 1; c <= 25; c++) begin
            exp_fd   = (c <= 10 && (c - 1) % 3 == 0) ? 4'(1 << ((c - 1) / 3)) : 4'b0;
            exp_bk   = (c >= 13 && c <= 22 && (c - 13) % 3 == 0) ? 4'(8 >> ((c - 13) / 3)) : 4'b0;
            exp_done = (c == 25);
            checks++; if (b_fd !== exp_fd) begin errors++; $display("FAIL train_fd cycle=%0d got=%b exp=%b", c, b_fd, exp_fd); end
            checks++; if (b_bk !== exp_bk) begin errors++; $display("FAIL train_bk cycle=%0d got=%b exp=%b", c, b_bk, exp_bk); end
            checks++; if (b_done !== exp_done) begin errors++; $display("FAIL train_done cycle=%0d got=%b exp=%b", c, b_done, exp_done); end
            step();
        end
        checks++; if (b_ready !== 1'b1 || b_count !== 16'd1 || b_osc !== 1'b1) begin errors++; $display("FAIL train_end ready=%b count=%0d osc=%b exp=1/1/1", b_ready, b_count, b_osc); end
    endtask

    task automatic test_single_layer();
        c_train = 0; c_start = 1;
        step();
        c_start = 0;
        checks++; if (c_fd !== 1'b1 || c_phase !== 2'd1) begin errors++; $display("FAIL n1_inf_fd fd=%b phase=%0d exp=1/1", c_fd, c_phase); end
        step();
        checks++; if (c_done !== 1'b1 || c_fd !== 1'b0) begin errors++; $display("FAIL n1_inf_done done=%b fd=%b exp=1/0", c_done, c_fd); end
        step();
        checks++; if (c_ready !== 1'b1 || c_count !== 16'd1) begin errors++; $display("FAIL n1_inf_end ready=%b count=%0d exp=1/1", c_ready, c_count); end
        c_train = 1; c_start = 1;
        step();
        c_start = 0;
        checks++; if (c_fd !== 1'b1 || c_bk !== 1'b0) begin errors++; $display("FAIL n1_tr_fd fd=%b bk=%b exp=1/0", c_fd, c_bk); end
        step();
        checks++; if (c_bk !== 1'b1 || c_fd !== 1'b0 || c_phase !== 2'd2) begin errors++; $display("FAIL n1_tr_bk bk=%b fd=%b phase=%0d exp=1/0/2", c_bk, c_fd, c_phase); end
        step();
        checks++; if (c_done !== 1'b1) begin errors++; $display("FAIL n1_tr_done got=%b exp=1", c_done); end
        step();
        checks++; if (c_ready !== 1'b1 || c_count !== 16'd2 || c_osc !== 1'b0) begin errors++; $display("FAIL n1_tr_end ready=%b count=%0d osc=%b exp=1/2/0", c_ready, c_count, c_osc); end
    endtask

    initial begin
        a_rst = 0; a_start = 0; a_train = 0; a_abort = 0;
        b_rst = 0; b_start = 0; b_train = 0; b_abort = 0;
        c_rst = 0; c_start = 0; c_train = 0; c_abort = 0;
        #1;
        test_reset();
        test_inference();
        test_abort_in_idle();
        test_abort();
        test_reset_mid();
        test_busy_wrap();
        test_training();
        test_single_layer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
